cpu65xx_seq_alu: RTL and testbench

- Parametrised multi-cycle arithmetic unit for 65xx-family cores (8-bit 6502/65C02, 16-bit 65816-class).
- Provides N-nibble BCD/binary add/subtract, plus iterative unsigned multiply and divide, one bit per cycle.
- Sits beside the single-cycle ALU; the microcode sequencer drives it through a valid/ready request port and consumes a valid/ready response port.

---
 rtl/cpu65xx_seq_alu_pkg.sv | 35 +++
 rtl/cpu65xx_seq_alu_if.sv | 33 +++
 rtl/cpu65xx_bcd_adder.sv | 49 ++++
 rtl/cpu65xx_seq_alu.sv | 200 ++++++++++++++++++++
 tb/tb_cpu65xx_seq_alu.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu65xx_seq_alu_pkg.sv
// Shared encodings and payload types for the multi-cycle 65xx arithmetic unit.
package cpu65xx_seq_alu_pkg;

  localparam int unsigned SEQ_OP_W  = 2;
  localparam int unsigned SEQ_MAX_W = 32;

  typedef enum logic [SEQ_OP_W-1:0] {
    SEQ_OP_ADD = 2'd0,
    SEQ_OP_SUB = 2'd1,
    SEQ_OP_MUL = 2'd2,
    SEQ_OP_DIV = 2'd3
  } seq_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
    logic div_by_zero;
  } seq_flags_t;

  // Response payload sized for the widest configuration; narrower units zero-extend.
  typedef struct packed {
    logic [SEQ_MAX_W-1:0] res_lo;
    logic [SEQ_MAX_W-1:0] res_hi;
    seq_flags_t           flags;
  } seq_rsp_t;

endpackage

// File: rtl/cpu65xx_seq_alu_if.sv
// Request/response port bundle between the microcode sequencer and the unit.
interface cpu65xx_seq_alu_if
  import cpu65xx_seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);
  logic                inValid;
  logic                inReady;
  logic [SEQ_OP_W-1:0] op;
  logic [WIDTH-1:0]    operandA;
  logic [WIDTH-1:0]    operandB;
  logic                carryIn;
  logic                decimalMode;
  logic                outValid;
  logic                outReady;
  logic [WIDTH-1:0]    resultLo;
  logic [WIDTH-1:0]    resultHi;
  logic                carryOut;
  logic                overflowOut;
  logic                zero;
  logic                negative;
  logic                divByZero;

  modport master (
    output inValid, op, operandA, operandB, carryIn, decimalMode, outReady,
    input  inReady, outValid, resultLo, resultHi, carryOut, overflowOut, zero, negative, divByZero
  );

  modport slave (
    input  inValid, op, operandA, operandB, carryIn, decimalMode, outReady,
    output inReady, outValid, resultLo, resultHi, carryOut, overflowOut, zero, negative, divByZero
  );
endinterface

// File: rtl/cpu65xx_bcd_adder.sv
// Combinational N-digit binary/BCD adder; subtraction expects B already inverted.
module cpu65xx_bcd_adder #(
  parameter int unsigned DIGITS = 2
) (
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                carry_in,
  input  logic                decimal,
  input  logic                subtract,
  output logic [4*DIGITS-1:0] sum,
  output logic                carry_out,
  output logic                overflow
);
  localparam int unsigned W = 4 * DIGITS;

  logic [W:0]   bin_full;
  logic [W-1:0] dec_sum;
  logic         dec_carry;

  assign bin_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry_in};

  // Decimal digit chain: +6 on add overflow past 9, +10 (mod 16) on subtract borrow.
  always_comb begin
    logic [4:0] raw;
    logic       c;
    dec_sum = '0;
    raw     = '0;
    c       = carry_in;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      raw = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
      if (subtract) begin
        c = raw[4];
        dec_sum[4*i +: 4] = c ? raw[3:0] : 4'(raw[3:0] + 4'd10);
      end else if (raw > 5'd9) begin
        c = 1'b1;
        dec_sum[4*i +: 4] = 4'(raw[3:0] + 4'd6);
      end else begin
        c = 1'b0;
        dec_sum[4*i +: 4] = raw[3:0];
      end
    end
    dec_carry = c;
  end

  assign sum       = decimal ? dec_sum : bin_full[W-1:0];
  assign carry_out = decimal ? dec_carry : bin_full[W];
  // V follows the binary sum in both modes, as on NMOS 6502 parts.
  assign overflow  = (a[W-1] == b[W-1]) && (bin_full[W-1] != a[W-1]);
endmodule

// File: rtl/cpu65xx_seq_alu.sv
// Multi-cycle add/sub (binary or BCD), shift-add multiply and restoring divide.
module cpu65xx_seq_alu
  import cpu65xx_seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic              clk,
  input logic              resetN,
  cpu65xx_seq_alu_if.slave bus
);
  localparam int unsigned CNT_W  = $clog2(WIDTH) + 1;
  localparam int unsigned DIGITS = WIDTH / 4;

  seq_state_e       state_q, state_d;
  seq_op_e          op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  seq_flags_t       flags_q, flags_d;

  seq_op_e          req_op;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_c;
  logic             add_v;

  assign req_op = seq_op_e'(bus.op);
  assign add_b  = (req_op == SEQ_OP_SUB) ? ~bus.operandB : bus.operandB;

  cpu65xx_bcd_adder #(
    .DIGITS (DIGITS)
  ) u_bcd_adder (
    .a         (bus.operandA),
    .b         (add_b),
    .carry_in  (bus.carryIn),
    .decimal   (bus.decimalMode),
    .subtract  (req_op == SEQ_OP_SUB),
    .sum       (add_sum),
    .carry_out (add_c),
    .overflow  (add_v)
  );

  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] it_a;
  logic [WIDTH:0] it_b;
  logic [WIDTH:0] it_sum;
  logic           it_ci;

  // Shared iteration adder: partial-product add for MUL, trial subtract for DIV.
  always_comb begin
    div_shift = {acc_q, lo_q[WIDTH-1]};
    if (op_q == SEQ_OP_MUL) begin
      it_a  = {1'b0, acc_q};
      it_b  = lo_q[0] ? {1'b0, opnd_q} : '0;
      it_ci = 1'b0;
    end else begin
      it_a  = div_shift;
      it_b  = ~{1'b0, opnd_q};
      it_ci = 1'b1;
    end
    it_sum = it_a + it_b + {{WIDTH{1'b0}}, it_ci};
  end

  // Next-state and datapath: capture on accept, iterate, then hold the response.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    flags_d  = flags_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.inValid && in_ready_q) begin
          op_d    = req_op;
          flags_d = '0;
          case (req_op)
            SEQ_OP_ADD, SEQ_OP_SUB: begin
              res_lo_d         = add_sum;
              res_hi_d         = '0;
              flags_d.carry    = add_c;
              flags_d.overflow = add_v;
              flags_d.zero     = ~|add_sum;
              flags_d.negative = add_sum[WIDTH-1];
              state_d          = ST_DONE;
            end
            SEQ_OP_MUL: begin
              opnd_d  = bus.operandA;
              lo_d    = bus.operandB;
              acc_d   = '0;
              cnt_d   = CNT_W'(WIDTH - 1);
              state_d = ST_ITER;
            end
            default: begin
              if (bus.operandB == '0) begin
                res_lo_d            = '1;
                res_hi_d            = bus.operandA;
                flags_d.negative    = 1'b1;
                flags_d.div_by_zero = 1'b1;
                state_d             = ST_DONE;
              end else begin
                opnd_d  = bus.operandB;
                lo_d    = bus.operandA;
                acc_d   = '0;
                cnt_d   = CNT_W'(WIDTH - 1);
                state_d = ST_ITER;
              end
            end
          endcase
        end
      end

      ST_ITER: begin
        if (op_q == SEQ_OP_MUL) begin
          acc_d = it_sum[WIDTH:1];
          lo_d  = {it_sum[0], lo_q[WIDTH-1:1]};
        end else if (!it_sum[WIDTH]) begin
          acc_d = it_sum[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = div_shift[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d  = ST_DONE;
          res_lo_d = lo_d;
          res_hi_d = acc_d;
          flags_d  = '0;
          if (op_q == SEQ_OP_MUL) begin
            flags_d.overflow = |acc_d;
            flags_d.zero     = ~|{acc_d, lo_d};
            flags_d.negative = acc_d[WIDTH-1];
          end else begin
            flags_d.zero     = ~|lo_d;
            flags_d.negative = lo_d[WIDTH-1];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_DONE: begin
        if (bus.outReady) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q     <= ST_IDLE;
      op_q        <= SEQ_OP_ADD;
      opnd_q      <= '0;
      acc_q       <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      res_lo_q    <= '0;
      res_hi_q    <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      opnd_q      <= opnd_d;
      acc_q       <= acc_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      res_lo_q    <= res_lo_d;
      res_hi_q    <= res_hi_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.inReady     = in_ready_q;
  assign bus.outValid    = out_valid_q;
  assign bus.resultLo    = res_lo_q;
  assign bus.resultHi    = res_hi_q;
  assign bus.carryOut    = flags_q.carry;
  assign bus.overflowOut = flags_q.overflow;
  assign bus.zero        = flags_q.zero;
  assign bus.negative    = flags_q.negative;
  assign bus.divByZero   = flags_q.div_by_zero;
endmodule

// File: tb/tb_cpu65xx_seq_alu.sv
// Scoreboard bench: 8-bit and 16-bit units, directed vectors, monitors pop and compare.
module tb_cpu65xx_seq_alu;
  import cpu65xx_seq_alu_pkg::*;

  typedef struct {
    seq_rsp_t rsp;
    int       lat;
    bit       chk_v;
    int       id;
  } exp_t;

  logic clk = 1'b0;
  logic resetN;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpu65xx_seq_alu_if #(.WIDTH(8))  bif8 ();
  cpu65xx_seq_alu_if #(.WIDTH(16)) bif16 ();

  cpu65xx_seq_alu #(.WIDTH(8))  u_dut8  (.clk(clk), .resetN(resetN), .bus(bif8.slave));
  cpu65xx_seq_alu #(.WIDTH(16)) u_dut16 (.clk(clk), .resetN(resetN), .bus(bif16.slave));

  exp_t q8[$];
  exp_t q16[$];
  int   tot_s = 0, pass_s = 0;
  int   tot8 = 0, pass8 = 0;
  int   tot16 = 0, pass16 = 0;
  int   acc8 = 0, acc16 = 0;

  function automatic seq_flags_t mkf(input bit c, input bit v, input bit z, input bit n, input bit dz);
    seq_flags_t f;
    f = {c, v, z, n, dz};
    return f;
  endfunction

  function automatic seq_rsp_t mkr(input logic [31:0] lo, input logic [31:0] hi, input seq_flags_t f);
    seq_rsp_t r;
    r.res_lo = lo;
    r.res_hi = hi;
    r.flags  = f;
    return r;
  endfunction

  task automatic chk_s(input bit ok, input string what, input logic [31:0] act, input logic [31:0] want);
    tot_s++;
    if (ok) pass_s++;
    else $display("FAIL stim %s: got 0x%0h want 0x%0h", what, act, want);
  endtask

  task automatic chk8(input bit ok, input int id, input string what, input logic [31:0] act, input logic [31:0] want);
    tot8++;
    if (ok) pass8++;
    else $display("FAIL dut8 #%0d %s: got 0x%0h want 0x%0h", id, what, act, want);
  endtask

  task automatic chk16(input bit ok, input int id, input string what, input logic [31:0] act, input logic [31:0] want);
    tot16++;
    if (ok) pass16++;
    else $display("FAIL dut16 #%0d %s: got 0x%0h want 0x%0h", id, what, act, want);
  endtask

  // Accept edges are recorded from pre-edge values so latency is measured from the handshake.
  always @(posedge clk) begin
    if (bif8.inValid && bif8.inReady)   acc8  <= cyc + 1;
    if (bif16.inValid && bif16.inReady) acc16 <= cyc + 1;
  end

  // Issue one request on the 8-bit unit; the caller is at a negedge.
  task automatic issue8(input seq_op_e op, input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic d, input bit expect_rsp, input seq_rsp_t rsp, input int lat,
                        input bit chk_v, input int id);
    exp_t e;
    int   n;
    if (expect_rsp) begin
      e.rsp = rsp; e.lat = lat; e.chk_v = chk_v; e.id = id;
      q8.push_back(e);
    end
    bif8.op = op; bif8.operandA = a; bif8.operandB = b; bif8.carryIn = c; bif8.decimalMode = d;
    bif8.inValid = 1'b1;
    n = 0;
    while (!bif8.inReady && n < 100) begin @(negedge clk); n++; end
    chk_s(bif8.inReady, "dut8 accept timeout", 32'(bif8.inReady), 32'd1);
    @(negedge clk);
    bif8.inValid = 1'b0;
  endtask

  task automatic issue16(input seq_op_e op, input logic [15:0] a, input logic [15:0] b, input logic c,
                         input logic d, input seq_rsp_t rsp, input int lat, input bit chk_v, input int id);
    exp_t e;
    int   n;
    e.rsp = rsp; e.lat = lat; e.chk_v = chk_v; e.id = id;
    q16.push_back(e);
    bif16.op = op; bif16.operandA = a; bif16.operandB = b; bif16.carryIn = c; bif16.decimalMode = d;
    bif16.inValid = 1'b1;
    n = 0;
    while (!bif16.inReady && n < 100) begin @(negedge clk); n++; end
    chk_s(bif16.inReady, "dut16 accept timeout", 32'(bif16.inReady), 32'd1);
    @(negedge clk);
    bif16.inValid = 1'b0;
  endtask

  // 8-bit monitor: first valid cycle pops and compares; later valid cycles check hold.
  bit          seen8 = 1'b0;
  logic [31:0] h8lo, h8hi;
  seq_flags_t  h8f;
  exp_t        e8;
  always @(negedge clk) begin
    if (!bif8.outValid) seen8 = 1'b0;
    else if (!seen8) begin
      seen8 = 1'b1;
      h8lo = {24'd0, bif8.resultLo};
      h8hi = {24'd0, bif8.resultHi};
      h8f  = {bif8.carryOut, bif8.overflowOut, bif8.zero, bif8.negative, bif8.divByZero};
      if (q8.size() == 0) chk8(1'b0, -1, "unexpected response", h8lo, 32'd0);
      else begin
        e8 = q8.pop_front();
        chk8(h8lo == e8.rsp.res_lo, e8.id, "resultLo", h8lo, e8.rsp.res_lo);
        chk8(h8hi == e8.rsp.res_hi, e8.id, "resultHi", h8hi, e8.rsp.res_hi);
        chk8((h8f & (e8.chk_v ? 5'h1f : 5'h17)) == (e8.rsp.flags & (e8.chk_v ? 5'h1f : 5'h17)),
             e8.id, "flags CVZND", 32'(h8f), 32'(e8.rsp.flags));
        chk8(cyc - acc8 + 1 == e8.lat, e8.id, "latency", 32'(cyc - acc8 + 1), 32'(e8.lat));
      end
    end else begin
      chk8({24'd0, bif8.resultLo} == h8lo && {24'd0, bif8.resultHi} == h8hi &&
           seq_flags_t'({bif8.carryOut, bif8.overflowOut, bif8.zero, bif8.negative, bif8.divByZero}) == h8f,
           e8.id, "held output", {24'd0, bif8.resultLo}, h8lo);
      chk8(!bif8.inReady, e8.id, "inReady while done", 32'(bif8.inReady), 32'd0);
    end
  end

  bit          seen16 = 1'b0;
  logic [31:0] h16lo, h16hi;
  seq_flags_t  h16f;
  exp_t        e16;
  always @(negedge clk) begin
    if (!bif16.outValid) seen16 = 1'b0;
    else if (!seen16) begin
      seen16 = 1'b1;
      h16lo = {16'd0, bif16.resultLo};
      h16hi = {16'd0, bif16.resultHi};
      h16f  = {bif16.carryOut, bif16.overflowOut, bif16.zero, bif16.negative, bif16.divByZero};
      if (q16.size() == 0) chk16(1'b0, -1, "unexpected response", h16lo, 32'd0);
      else begin
        e16 = q16.pop_front();
        chk16(h16lo == e16.rsp.res_lo, e16.id, "resultLo", h16lo, e16.rsp.res_lo);
        chk16(h16hi == e16.rsp.res_hi, e16.id, "resultHi", h16hi, e16.rsp.res_hi);
        chk16((h16f & (e16.chk_v ? 5'h1f : 5'h17)) == (e16.rsp.flags & (e16.chk_v ? 5'h1f : 5'h17)),
              e16.id, "flags CVZND", 32'(h16f), 32'(e16.rsp.flags));
        chk16(cyc - acc16 + 1 == e16.lat, e16.id, "latency", 32'(cyc - acc16 + 1), 32'(e16.lat));
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 500) begin @(negedge clk); n++; end
    chk_s(q8.size() == 0 && q16.size() == 0, "drain timeout", 32'(q8.size() + q16.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    resetN = 1'b0;
    bif8.inValid = 1'b0; bif8.op = '0; bif8.operandA = '0; bif8.operandB = '0;
    bif8.carryIn = 1'b0; bif8.decimalMode = 1'b0; bif8.outReady = 1'b1;
    bif16.inValid = 1'b0; bif16.op = '0; bif16.operandA = '0; bif16.operandB = '0;
    bif16.carryIn = 1'b0; bif16.decimalMode = 1'b0; bif16.outReady = 1'b1;
    repeat (2) @(negedge clk);

    chk_s(!bif8.inReady && !bif8.outValid, "reset hs8", {30'd0, bif8.inReady, bif8.outValid}, 32'd0);
    chk_s(bif8.resultLo == 8'd0 && bif8.resultHi == 8'd0, "reset res8", {16'd0, bif8.resultHi, bif8.resultLo}, 32'd0);
    chk_s(!bif16.inReady && !bif16.outValid && bif16.resultLo == 16'd0, "reset dut16",
          {14'd0, bif16.inReady, bif16.outValid, bif16.resultLo}, 32'd0);
    resetN = 1'b1;
    @(negedge clk);
    chk_s(bif8.inReady && bif16.inReady, "ready after reset", {30'd0, bif8.inReady, bif16.inReady}, 32'd3);

    // 8-bit add/sub, binary and decimal
    issue8(SEQ_OP_ADD, 8'h45, 8'h38, 1'b0, 1'b1, 1'b1, mkr(32'h83, 0, mkf(0, 0, 0, 1, 0)), 1, 1'b0, 1);
    issue8(SEQ_OP_SUB, 8'h00, 8'h01, 1'b1, 1'b1, 1'b1, mkr(32'h99, 0, mkf(0, 0, 0, 1, 0)), 1, 1'b0, 2);
    issue8(SEQ_OP_SUB, 8'h00, 8'h01, 1'b1, 1'b0, 1'b1, mkr(32'hFF, 0, mkf(0, 0, 0, 1, 0)), 1, 1'b1, 3);
    issue8(SEQ_OP_ADD, 8'h99, 8'h01, 1'b0, 1'b1, 1'b1, mkr(32'h00, 0, mkf(1, 0, 1, 0, 0)), 1, 1'b0, 4);
    issue8(SEQ_OP_ADD, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, mkr(32'h80, 0, mkf(0, 1, 0, 1, 0)), 1, 1'b1, 5);
    issue8(SEQ_OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, mkr(32'h00, 0, mkf(1, 0, 1, 0, 0)), 1, 1'b1, 6);
    // 8-bit multiply/divide
    issue8(SEQ_OP_MUL, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, mkr(32'h01, 32'hFE, mkf(0, 1, 0, 1, 0)), 9, 1'b1, 7);
    issue8(SEQ_OP_MUL, 8'h00, 8'h37, 1'b0, 1'b0, 1'b1, mkr(32'h00, 32'h00, mkf(0, 0, 1, 0, 0)), 9, 1'b1, 8);
    issue8(SEQ_OP_DIV, 8'hFF, 8'h10, 1'b0, 1'b0, 1'b1, mkr(32'h0F, 32'h0F, mkf(0, 0, 0, 0, 0)), 9, 1'b1, 9);
    issue8(SEQ_OP_DIV, 8'h05, 8'h00, 1'b0, 1'b0, 1'b1, mkr(32'hFF, 32'h05, mkf(0, 0, 0, 1, 1)), 1, 1'b1, 10);
    // 16-bit divide, divide by zero, decimal add across digits
    issue16(SEQ_OP_DIV, 16'h0064, 16'h0007, 1'b0, 1'b0, mkr(32'h000E, 32'h0002, mkf(0, 0, 0, 0, 0)), 17, 1'b1, 11);
    issue16(SEQ_OP_DIV, 16'h1234, 16'h0000, 1'b0, 1'b0, mkr(32'hFFFF, 32'h1234, mkf(0, 0, 0, 1, 1)), 1, 1'b1, 12);
    issue16(SEQ_OP_ADD, 16'h1999, 16'h0001, 1'b0, 1'b1, mkr(32'h2000, 0, mkf(0, 0, 0, 0, 0)), 1, 1'b0, 13);
    drain();

    // Backpressure: response held for 5 cycles, then released
    bif8.outReady = 1'b0;
    issue8(SEQ_OP_MUL, 8'h0C, 8'h0A, 1'b0, 1'b0, 1'b1, mkr(32'h78, 32'h00, mkf(0, 0, 0, 0, 0)), 9, 1'b1, 14);
    n = 0;
    while (!bif8.outValid && n < 50) begin @(negedge clk); n++; end
    chk_s(bif8.outValid, "MUL completion timeout", 32'(bif8.outValid), 32'd1);
    repeat (5) @(negedge clk);
    chk_s(bif8.outValid && !bif8.inReady, "stalled response", {30'd0, bif8.outValid, bif8.inReady}, 32'd2);
    bif8.outReady = 1'b1;
    @(negedge clk);
    chk_s(!bif8.outValid && bif8.inReady, "idle after release", {30'd0, bif8.outValid, bif8.inReady}, 32'd1);
    issue8(SEQ_OP_ADD, 8'h10, 8'h20, 1'b0, 1'b0, 1'b1, mkr(32'h30, 0, mkf(0, 0, 0, 0, 0)), 1, 1'b1, 15);
    drain();

    // Reset on the third ITER cycle of a MUL aborts it
    issue8(SEQ_OP_MUL, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, mkr(0, 0, mkf(0, 0, 0, 0, 0)), 0, 1'b0, 0);
    repeat (2) @(negedge clk);
    chk_s(!bif8.inReady && !bif8.outValid, "busy before abort", {30'd0, bif8.inReady, bif8.outValid}, 32'd0);
    resetN = 1'b0;
    @(negedge clk);
    chk_s(!bif8.outValid && !bif8.inReady, "abort handshake", {30'd0, bif8.outValid, bif8.inReady}, 32'd0);
    chk_s(bif8.resultLo == 8'd0 && bif8.resultHi == 8'd0 && !bif8.zero && !bif8.negative,
          "abort outputs", {16'd0, bif8.resultHi, bif8.resultLo}, 32'd0);
    resetN = 1'b1;
    @(negedge clk);
    chk_s(bif8.inReady, "ready after abort", 32'(bif8.inReady), 32'd1);
    issue8(SEQ_OP_ADD, 8'h01, 8'h01, 1'b0, 1'b0, 1'b1, mkr(32'h02, 0, mkf(0, 0, 0, 0, 0)), 1, 1'b1, 16);
    drain();
    repeat (12) @(negedge clk);
    chk_s(!bif8.outValid && q8.size() == 0, "no stale response", {31'd0, bif8.outValid}, 32'd0);

    $display("%0d/%0d checks passed", pass_s + pass8 + pass16, tot_s + tot8 + tot16);
    $finish;
  end
endmodule
